// File: rtl/digital_in_pkg.sv
// digital_in_pkg: command codes, FSM encodings and report word layout shared by digital_in
package digital_in_pkg;
    localparam int DEF_CMD_CONFIG_DIGITAL_IN = 5;
    localparam int DEF_CMD_QUERY_DIGITAL_IN = 6;
    localparam int W1_VALUE_BIT = 0;
    localparam int W1_OVERRUN_BIT = 1;
    typedef enum logic [1:0] {IDLE, CFG_1, QRY_1, QRY_2} cmd_state_e;
    typedef enum logic [2:0] {R_IDLE, R_REQ, R_W0, R_W1, R_W2} rep_state_e;
endpackage

// File: rtl/digital_in_sync_2ff.sv
// sync_2ff: W-bit two-flop synchronizer for asynchronous inputs
module sync_2ff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q <= '0;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/digital_in.sv
// digital_in: periodic sampling of gpio pins with change reports sent over the involuntary channel
module digital_in
    import digital_in_pkg::*;
#(
    parameter int NGPIO = 8,
    parameter int CMD_BITS = 8,
    parameter int CMD_CONFIG_DIGITAL_IN = DEF_CMD_CONFIG_DIGITAL_IN,
    parameter int CMD_QUERY_DIGITAL_IN = DEF_CMD_QUERY_DIGITAL_IN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         systime,
    input  logic [31:0]         arg_data,
    output logic                arg_advance,
    input  logic [CMD_BITS-1:0] cmd,
    input  logic                cmd_ready,
    output logic                cmd_done,
    output logic [31:0]         param_data,
    output logic                param_write,
    output logic                invol_req,
    input  logic                invol_grant,
    input  logic [NGPIO-1:0]    gpio_in
);
    localparam int CW = NGPIO > 1 ? $clog2(NGPIO) : 1;

    cmd_state_e state, state_n;
    rep_state_e rstate, rstate_n;
    logic [CW-1:0] channel, last_rep, sel, tx_ch;
    logic [NGPIO-1:0] synced, value, invert, last, first, pending, overrun, hit, qwr, clr;
    logic [31:0] next_time [NGPIO];
    logic [31:0] rest_ticks [NGPIO];
    logic [31:0] stamp [NGPIO];
    logic [31:0] tx_stamp, data_q, word, w1;
    logic tx_val, tx_ovr, take, known, done_n;

    function automatic logic [CW-1:0] rr_pick(input logic [NGPIO-1:0] p, input logic [CW-1:0] from);
        logic [CW-1:0] k;
        rr_pick = from;
        for (int i = NGPIO; i >= 1; i--) begin
            k = CW'((int'(from) + i) % NGPIO);
            if (p[k]) rr_pick = k;
        end
    endfunction

    sync_2ff #(.W(NGPIO)) u_sync (.clk(clk), .rst(rst), .d(gpio_in), .q(synced));

    assign value = synced ^ invert;
    assign arg_advance = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rstate <= R_IDLE;
        end else begin
            state <= state_n;
            rstate <= rstate_n;
        end
    end

    always_comb begin
        known = cmd == CMD_BITS'(CMD_CONFIG_DIGITAL_IN) || cmd == CMD_BITS'(CMD_QUERY_DIGITAL_IN);
        state_n = state == IDLE ? (!cmd_ready ? IDLE :
                                   cmd == CMD_BITS'(CMD_CONFIG_DIGITAL_IN) ? CFG_1 :
                                   cmd == CMD_BITS'(CMD_QUERY_DIGITAL_IN) ? QRY_1 : IDLE) :
                  state == QRY_1 ? QRY_2 : IDLE;
        done_n = state == CFG_1 || state == QRY_2 || (state == IDLE && cmd_ready && !known);
        rstate_n = rstate == R_IDLE ? (|pending ? R_REQ : R_IDLE) :
                   rstate == R_REQ ? (invol_grant ? R_W0 : R_REQ) :
                   rstate == R_W0 ? R_W1 :
                   rstate == R_W1 ? R_W2 : R_IDLE;
        w1 = '0;
        w1[W1_VALUE_BIT] = tx_val;
        w1[W1_OVERRUN_BIT] = tx_ovr;
        word = rstate == R_W0 ? 32'(tx_ch) : rstate == R_W1 ? w1 : tx_stamp;
        invol_req = rstate == R_REQ;
        param_write = rstate == R_W0 || rstate == R_W1 || rstate == R_W2;
        param_data = param_write ? word : data_q;
        sel = rr_pick(pending, last_rep);
        take = rstate == R_IDLE && |pending;
        for (int c = 0; c < NGPIO; c++) begin
            hit[c] = rest_ticks[c] != 0 && systime == next_time[c];
            qwr[c] = (state == QRY_1 || state == QRY_2) && channel == CW'(c);
            clr[c] = take && sel == CW'(c);
        end
    end

    // A query write to a channel takes precedence over that channel's sample in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            channel <= '0;
            last_rep <= '0;
            cmd_done <= 1'b0;
            data_q <= '0;
            tx_ch <= '0;
            tx_val <= 1'b0;
            tx_ovr <= 1'b0;
            tx_stamp <= '0;
            invert <= '0;
            last <= '0;
            first <= '0;
            pending <= '0;
            overrun <= '0;
            for (int c = 0; c < NGPIO; c++) begin
                next_time[c] <= '0;
                rest_ticks[c] <= '0;
                stamp[c] <= '0;
            end
        end else begin
            cmd_done <= done_n;
            if (state == IDLE && cmd_ready) channel <= arg_data[CW-1:0];
            if (state == CFG_1) invert[channel] <= arg_data[0];
            if (param_write) data_q <= word;
            if (take) begin
                tx_ch <= sel;
                tx_val <= last[sel];
                tx_ovr <= overrun[sel];
                tx_stamp <= stamp[sel];
                last_rep <= sel;
            end
            for (int c = 0; c < NGPIO; c++) begin
                if (clr[c]) begin
                    pending[c] <= 1'b0;
                    overrun[c] <= 1'b0;
                end
                if (qwr[c] && state == QRY_1) begin
                    next_time[c] <= arg_data;
                end else if (qwr[c]) begin
                    rest_ticks[c] <= arg_data;
                    first[c] <= 1'b1;
                    pending[c] <= 1'b0;
                    overrun[c] <= 1'b0;
                end else if (hit[c]) begin
                    next_time[c] <= next_time[c] + rest_ticks[c];
                    if (first[c] || value[c] != last[c]) begin
                        pending[c] <= 1'b1;
                        overrun[c] <= (overrun[c] | pending[c]) & ~clr[c];
                        last[c] <= value[c];
                        stamp[c] <= systime;
                        first[c] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_digital_in.sv
// tb_digital_in: command table, hand-written report scenarios and randomized pin traffic for digital_in
module tb_digital_in;
    localparam int NG = 8;
    localparam logic [7:0] CFG = 8'd5;
    localparam logic [7:0] QRY = 8'd6;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] systime = '0, arg_data = '0;
    logic [7:0] cmd = '0;
    logic cmd_ready = 1'b0, invol_grant = 1'b0;
    logic [NG-1:0] gpio_in = '0;
    logic arg_advance, cmd_done, param_write, invol_req;
    logic [31:0] param_data;

    int n_tests = 0, n_fail = 0;
    logic [31:0] wq[$];
    int wc[$];
    int cyc = 0;
    bit grant_en = 1'b1;
    bit pin_at [int unsigned];

    typedef struct {
        logic [7:0]  c;
        logic [31:0] oid, a1, a2;
        int          lat;
    } cmd_vec_t;
    cmd_vec_t vecs[6];

    digital_in dut (
        .clk(clk), .rst(rst), .systime(systime), .arg_data(arg_data), .arg_advance(arg_advance),
        .cmd(cmd), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .param_data(param_data),
        .param_write(param_write), .invol_req(invol_req), .invol_grant(invol_grant), .gpio_in(gpio_in)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (param_write) begin
            wq.push_back(param_data);
            wc.push_back(cyc);
        end
    end

    initial forever begin
        @(negedge clk);
        invol_grant = grant_en && invol_req;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            systime = systime + 1;
        end
    endtask

    task automatic run_to(logic [31:0] t);
        int b = 0;
        while (systime != t && b < 2000) begin
            tick();
            b++;
        end
        if (systime != t) check("run_to", systime, t);
    endtask

    task automatic do_cmd(string nm, logic [7:0] c, logic [31:0] oid, logic [31:0] a1, logic [31:0] a2, int lat);
        cmd = c;
        cmd_ready = 1'b1;
        arg_data = oid;
        for (int k = 1; k <= lat; k++) begin
            tick();
            cmd_ready = 1'b0;
            arg_data = k == 1 ? a1 : a2;
            check({nm, " done"}, 32'(cmd_done), 32'(k == lat));
        end
        tick();
        check({nm, " done clr"}, 32'(cmd_done), 0);
    endtask

    task automatic wait_report(string nm, logic [31:0] ech, logic [31:0] ew1, logic [31:0] est);
        int b = 0;
        int c0, c2;
        while (wq.size() < 3 && b < 400) begin
            tick();
            b++;
        end
        if (wq.size() < 3) begin
            check({nm, " timeout"}, wq.size(), 3);
            return;
        end
        check({nm, " w0"}, wq.pop_front(), ech);
        check({nm, " w1"}, wq.pop_front(), ew1);
        check({nm, " w2"}, wq.pop_front(), est);
        c0 = wc.pop_front();
        void'(wc.pop_front());
        c2 = wc.pop_front();
        check({nm, " consecutive"}, c2 - c0, 2);
    endtask

    initial begin
        vecs[0] = '{8'd0, 32'd0, 32'd0, 32'd0, 1};
        vecs[1] = '{CFG, 32'd3, 32'd1, 32'd0, 2};
        vecs[2] = '{QRY, 32'd4, 32'd0, 32'd0, 3};
        vecs[3] = '{8'd7, 32'd1, 32'd0, 32'd0, 1};
        vecs[4] = '{8'd255, 32'd2, 32'd0, 32'd0, 1};
        vecs[5] = '{CFG, 32'd3, 32'd0, 32'd0, 2};

        tick(3);
        check("rst cmd_done", 32'(cmd_done), 0);
        check("rst param_write", 32'(param_write), 0);
        check("rst param_data", param_data, 0);
        check("rst invol_req", 32'(invol_req), 0);
        check("arg_advance", 32'(arg_advance), 1);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) do_cmd($sformatf("vec%0d", i), vecs[i].c, vecs[i].oid, vecs[i].a1, vecs[i].a2, vecs[i].lat);
        check("no reports after table", wq.size(), 0);

        systime = 900;
        do_cmd("cfg2", CFG, 2, 0, 0, 2);
        do_cmd("qry2", QRY, 2, 1000, 100, 3);
        wait_report("ch2 first", 2, 0, 1000);
        run_to(1110);
        check("ch2 unchanged quiet", wq.size(), 0);
        run_to(1150);
        gpio_in[2] = 1'b1;
        wait_report("ch2 rise", 2, 1, 1200);
        do_cmd("off2", QRY, 2, 0, 0, 3);

        systime = 30;
        gpio_in[0] = 1'b1;
        do_cmd("cfg0", CFG, 0, 1, 0, 2);
        do_cmd("qry0", QRY, 0, 50, 10, 3);
        wait_report("ch0 invert", 0, 0, 50);
        do_cmd("off0", QRY, 0, 0, 0, 3);

        grant_en = 1'b0;
        systime = 100;
        do_cmd("cfg1", CFG, 1, 0, 0, 2);
        do_cmd("qry1", QRY, 1, 120, 10, 3);
        run_to(125);
        gpio_in[1] = 1'b1;
        run_to(135);
        gpio_in[1] = 1'b0;
        run_to(155);
        check("held req", 32'(invol_req), 1);
        check("held no writes", wq.size(), 0);
        grant_en = 1'b1;
        wait_report("ch1 first", 1, 0, 120);
        wait_report("ch1 overrun", 1, 2, 140);
        tick(20);
        check("ch1 quiet", wq.size(), 0);
        do_cmd("off1", QRY, 1, 0, 0, 3);

        systime = 32'hFFFF_FFE0;
        do_cmd("cfg3", CFG, 3, 0, 0, 2);
        do_cmd("qry3", QRY, 3, 32'hFFFF_FFF0, 32'h20, 3);
        wait_report("wrap first", 3, 0, 32'hFFFF_FFF0);
        run_to(32'hFFFF_FFF8);
        gpio_in[3] = 1'b1;
        wait_report("wrap second", 3, 1, 32'h10);
        do_cmd("off3", QRY, 3, 0, 0, 3);

        for (int r = 0; r < 4; r++) begin
            logic [2:0] ch;
            logic inv, v, prev;
            bit fst;
            logic [31:0] t0, tend, rest;
            logic [31:0] exp_v[$], exp_t[$];
            exp_v.delete();
            exp_t.delete();
            pin_at.delete();
            ch = 3'($urandom_range(0, NG - 1));
            inv = 1'($urandom_range(0, 1));
            rest = $urandom_range(6, 12);
            t0 = systime + 20;
            tend = t0 + 160;
            do_cmd("rnd cfg", CFG, 32'(ch), 32'(inv), 0, 2);
            do_cmd("rnd qry", QRY, 32'(ch), t0, rest, 3);
            while (systime < tend) begin
                if (systime < tend - 30 && $urandom_range(0, 7) == 0) gpio_in[ch] = ~gpio_in[ch];
                pin_at[systime] = gpio_in[ch];
                tick();
            end
            fst = 1'b1;
            prev = 1'b0;
            for (logic [31:0] t = t0; t < tend; t += rest) begin
                v = pin_at[t - 2] ^ inv;
                if (fst || v != prev) begin
                    exp_v.push_back(32'(v));
                    exp_t.push_back(t);
                end
                fst = 1'b0;
                prev = v;
            end
            do_cmd("rnd off", QRY, 32'(ch), 0, 0, 3);
            foreach (exp_v[i]) wait_report($sformatf("rnd%0d.%0d", r, i), 32'(ch), exp_v[i], exp_t[i]);
            check("rnd extra", wq.size(), 0);
        end

        begin
            int b = 0;
            wq.delete();
            wc.delete();
            systime = 200;
            gpio_in[5] = 1'b0;
            do_cmd("cfg5", CFG, 5, 0, 0, 2);
            do_cmd("qry5", QRY, 5, 215, 5, 3);
            while (!param_write && b < 100) begin
                tick();
                b++;
            end
            check("rst w0 seen", 32'(param_write), 1);
            tick();
            check("rst w1 seen", 32'(param_write), 1);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst no w2", 32'(param_write), 0);
            check("rst req low", 32'(invol_req), 0);
            check("rst data zero", param_data, 0);
            check("rst no done", 32'(cmd_done), 0);
            check("rst words", wq.size(), 2);
            for (int i = 0; i < 60; i++) begin
                if (i % 3 == 0) gpio_in[5] = ~gpio_in[5];
                tick();
            end
            check("rst quiet", wq.size(), 2);
            check("rst quiet req", 32'(invol_req), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/digital_in.md
DIGITAL_IN -- requirements
Module: digital_in

Interface
REQ-001 Parameter NGPIO, default 8, number of input channels.
REQ-002 Parameter CMD_BITS, default 8, command code width.
REQ-003 Parameter CMD_CONFIG_DIGITAL_IN, default 5, code for "config_digital_in oid=%c invert=%c".
REQ-004 Parameter CMD_QUERY_DIGITAL_IN, default 6, code for "query_digital_in oid=%c clock=%u rest_ticks=%u".
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 systime  in  32  free-running system time.
REQ-008 arg_data  in  32  current command argument.
REQ-009 arg_advance  out  1  argument consumed; tied to 1, one argument per clock.
REQ-010 cmd  in  CMD_BITS  command code, valid with cmd_ready.
REQ-011 cmd_ready  in  1  command pending; first argument (oid) present on arg_data.
REQ-012 cmd_done  out  1  one-cycle pulse, command finished.
REQ-013 param_data  out  32  report word.
REQ-014 param_write  out  1  param_data valid this cycle.
REQ-015 invol_req  out  1  request to send an involuntary report.
REQ-016 invol_grant  in  1  report channel granted.
REQ-017 gpio_in  in  NGPIO  asynchronous input pins.

Function
REQ-018 Each gpio_in bit SHALL pass a 2-flop synchronizer; sampled value = synced bit XOR invert[ch].
REQ-019 Command FSM states: IDLE, CFG_1, QRY_1, QRY_2; in IDLE with cmd_ready, channel <= arg_data[$clog2(NGPIO)-1:0].
REQ-020 CONFIG: IDLE->CFG_1; CFG_1 stores invert[ch]=arg_data[0], pulses cmd_done, returns IDLE.
REQ-021 QUERY: IDLE->QRY_1 stores next_time[ch]=arg_data; QRY_2 stores rest_ticks[ch]=arg_data, sets first[ch], clears pending[ch], pulses cmd_done, returns IDLE.
REQ-022 Unknown cmd SHALL pulse cmd_done the cycle after cmd_ready, state stays IDLE.
REQ-023 rest_ticks[ch]==0 SHALL mean channel disabled: no sampling, no reports.
REQ-024 Enabled channel with systime==next_time[ch]: sample; next_time[ch] += rest_ticks[ch] modulo 2^32 (wrap-around is normal).
REQ-025 At a sample, if first[ch] or value != last[ch]: pending[ch]=1, last[ch]=value, stamp[ch]=systime, first[ch]=0.
REQ-026 Change while pending[ch] already set: overwrite value/stamp and set overrun[ch].
REQ-027 Query write to a channel in the same cycle as its sample: command write wins, sample discarded.
REQ-028 Reporter FSM: R_IDLE, R_REQ, R_W0, R_W1, R_W2; round-robin scan from channel after last reported.
REQ-029 R_IDLE with any pending: latch channel, value, stamp, overrun into TX registers, clear that pending/overrun, assert invol_req, go R_REQ.
REQ-030 invol_req SHALL stay high until the cycle after invol_grant is seen; then deassert.
REQ-031 After grant, three consecutive param_write cycles: W0 = channel zero-extended, W1 = {30'b0, overrun, value}, W2 = stamp; then R_IDLE.
REQ-032 New sample on the channel in transmission SHALL not alter the words in flight; it becomes a new pending report.
REQ-033 param_write high only in R_W0..R_W2; param_data holds last word otherwise.

Reset
REQ-034 rst SHALL force cmd_done=0, param_write=0, param_data=0, invol_req=0, both FSMs idle, and all per-channel invert, next_time, rest_ticks, last, stamp, first, pending, overrun to 0, next cycle.
REQ-035 rst mid-report SHALL abort: no further param_write, invol_req low next cycle; rst mid-command drops the command without cmd_done.

Structure
REQ-036 Shared package SHALL hold command codes, reporter state encoding, W1 bit positions.
REQ-037 One sub-module, sync_2ff, NGPIO-wide 2-flop synchronizer with reset.

Verification
REQ-038 Config ch2 invert=0, query ch2 clock=1000 rest=100, pin low -> at systime 1000 report (2, 0x0, 1000); no report at 1100 while unchanged.
REQ-039 Pin ch2 raised at systime 1150 -> report (2, 0x1, 1200), word order W0,W1,W2 on three consecutive cycles after grant.
REQ-040 invert=1 on ch0, pin high, query clock=50 rest=10 -> first report value 0 at 50.
REQ-041 Hold invol_grant low, toggle ch1 across two samples -> single report with W1=0x2|value, newest stamp.
REQ-042 next_time=0xFFFFFFF0 rest=0x20 -> second sample at 0x10 after systime wrap.
REQ-043 Assert rst during W1 -> no W2 write, invol_req 0 next cycle, rest_ticks 0, no reports afterward.
